spi_cmd_master: RTL and testbench

SPI master that generates the command-prefixed test frames consumed by the on-chip SPI test decoder. Each frame carries:
- 1 chip-select command byte: 8'h01 = xp-adc, 8'h02 = xdac.
- 0..4 payload bytes.
- Mode 0 (CPOL=0, CPHA=0), MSB first.

The block sits on the bench/host-side FPGA, or drives the decoder's spi_csn/spi_sck/spi_sdi inputs in loopback tests. It captures the returned sdo bits into rdata.

---
 rtl/spi_cmd_master_pkg.sv | 56 +++++
 rtl/spi_cmd_master_if.sv | 28 ++
 rtl/spi_cmd_master_tick.sv | 30 +++
 rtl/spi_cmd_master.sv | 180 ++++++++++++++++++
 tb/tb_spi_cmd_master.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_cmd_master_pkg.sv
// Purpose: shared constants, FSM state encoding and payload helpers for spi_cmd_master.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package spi_cmd_master_pkg;

    localparam logic [7:0] CMD_XP_ADC        = 8'h01;
    localparam logic [7:0] CMD_XDAC          = 8'h02;
    localparam int         MAX_PAYLOAD_BYTES = 4;
    localparam int         FRAME_BITS        = 8 + 8 * MAX_PAYLOAD_BYTES;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HI    = 3'd2,
        LO    = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } state_t;

    // Requests longer than the payload field are treated as a full payload.
    function automatic logic [2:0] clamp_len(input logic [2:0] len);
        return (len > 3'(MAX_PAYLOAD_BYTES)) ? 3'(MAX_PAYLOAD_BYTES) : len;
    endfunction

    // Move the low len bytes of wdata to the top so they shift out MSB first.
    function automatic logic [31:0] align_payload(input logic [31:0] wdata, input logic [2:0] len);
        case (len)
            3'd0:    return 32'h0;
            3'd1:    return {wdata[7:0], 24'h0};
            3'd2:    return {wdata[15:0], 16'h0};
            3'd3:    return {wdata[23:0], 8'h0};
            default: return wdata;
        endcase
    endfunction

    // Keeps only the payload-period bits of the receive register.
    function automatic logic [31:0] payload_mask(input logic [2:0] len);
        case (len)
            3'd0:    return 32'h0000_0000;
            3'd1:    return 32'h0000_00FF;
            3'd2:    return 32'h0000_FFFF;
            3'd3:    return 32'h00FF_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/spi_cmd_master_if.sv
// Purpose: host request/response and SPI pin bundle for spi_cmd_master.
// Latency: n/a (wiring only).
// Backpressure: start is honoured only while busy is low; nothing is queued.
interface spi_cmd_master_if;

    logic        start;
    logic [7:0]  cmd;
    logic [2:0]  len;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        spi_csn;
    logic        spi_sck;
    logic        spi_sdi;
    logic        spi_sdo;

    modport master (
        input  start, cmd, len, wdata, spi_sdo,
        output busy, done, rdata, spi_csn, spi_sck, spi_sdi
    );

    modport slave (
        output start, cmd, len, wdata, spi_sdo,
        input  busy, done, rdata, spi_csn, spi_sck, spi_sdi
    );

endinterface

// File: rtl/spi_cmd_master_tick.sv
// Purpose: loadable down-counter timing every phase of the SPI frame (setup, SCK halves, hold, gap).
// Latency: o_tc asserts i_load_val cycles after the load edge, i.e. in the last cycle of an N-1 load.
// Backpressure: none; counting pauses while i_en is low and a load always wins.
module spi_cmd_master_tick #(
    parameter int W = 3
) (
    input  logic         clk_ref,
    input  logic         sys_rstn,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    // Reload on every phase change, otherwise count down to zero and park there.
    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_tc = i_en && (r_cnt == '0);

endmodule

// File: rtl/spi_cmd_master.sv
// Purpose: mode-0 SPI master sending a command byte plus 0..4 payload bytes and capturing sdo.
// Latency: csn low for CS_SETUP + 2*CLK_DIV*nbits + CS_HOLD cycles; done one cycle after that.
// Backpressure: start is ignored while busy; no request queueing.
module spi_cmd_master
    import spi_cmd_master_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 4
) (
    input  logic              clk_ref,
    input  logic              sys_rstn,
    spi_cmd_master_if.master  bus
);

    // One counter serves every timed phase, so it is sized for the longest one.
    localparam int MAX_T = max4(CLK_DIV, CS_SETUP, CS_HOLD, CS_IDLE);
    localparam int TW    = $clog2(MAX_T) + 1;

    state_t                r_state;
    state_t                w_next;
    logic [FRAME_BITS-1:0] r_tx;
    logic [31:0]           r_rx;
    logic [2:0]            r_len;
    logic [5:0]            r_bits;
    logic                  r_done;
    logic [31:0]           r_rdata;

    logic                  w_tc;
    logic                  w_load;
    logic [TW-1:0]         w_load_val;
    logic                  w_csn;
    logic                  w_sck;
    logic                  w_sdi;
    logic [2:0]            w_len_c;
    logic [5:0]            w_nbits;
    logic                  w_accept;
    logic                  w_fall;
    logic                  w_rise;
    logic                  w_frame_end;

    assign w_len_c     = clamp_len(bus.len);
    assign w_nbits     = 6'd8 + {r_len, 3'b000};
    assign w_accept    = (r_state == IDLE) && bus.start;
    assign w_fall      = (r_state == HI) && w_tc;
    assign w_rise      = ((r_state == SETUP) || (r_state == LO)) && (w_next == HI);
    assign w_frame_end = (r_state == HOLD) && w_tc;

    spi_cmd_master_tick #(.W(TW)) u_tick (
        .clk_ref    (clk_ref),
        .sys_rstn   (sys_rstn),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_en       (r_state != IDLE),
        .o_tc       (w_tc)
    );

    // State register; reset drops csn/sck combinationally with no extra SCK edge.
    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, phase-counter reload and pin levels decoded from the current state.
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        w_csn      = 1'b1;
        w_sck      = 1'b0;
        w_sdi      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next     = SETUP;
                    w_load     = 1'b1;
                    w_load_val = TW'(CS_SETUP - 1);
                end
            end
            SETUP: begin
                w_csn = 1'b0;
                w_sdi = r_tx[FRAME_BITS-1];
                if (w_tc) begin
                    w_next     = HI;
                    w_load     = 1'b1;
                    w_load_val = TW'(CLK_DIV - 1);
                end
            end
            HI: begin
                w_csn = 1'b0;
                w_sck = 1'b1;
                w_sdi = r_tx[FRAME_BITS-1];
                if (w_tc) begin
                    w_next     = LO;
                    w_load     = 1'b1;
                    w_load_val = TW'(CLK_DIV - 1);
                end
            end
            LO: begin
                w_csn = 1'b0;
                w_sdi = r_tx[FRAME_BITS-1];
                if (w_tc) begin
                    w_load = 1'b1;
                    // r_bits already counts the bit whose low phase is ending.
                    if (r_bits < w_nbits) begin
                        w_next     = HI;
                        w_load_val = TW'(CLK_DIV - 1);
                    end else begin
                        w_next     = HOLD;
                        w_load_val = TW'(CS_HOLD - 1);
                    end
                end
            end
            HOLD: begin
                w_csn = 1'b0;
                w_sdi = r_tx[FRAME_BITS-1];
                if (w_tc) begin
                    w_next     = GAP;
                    w_load     = 1'b1;
                    w_load_val = TW'(CS_IDLE - 1);
                end
            end
            GAP: begin
                if (w_tc) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Latch the request on acceptance, shift sdi on falling SCK, shift sdo in on rising SCK.
    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) begin
            r_tx   <= '0;
            r_len  <= '0;
            r_bits <= '0;
            r_rx   <= '0;
        end else begin
            if (w_accept) begin
                r_tx   <= {bus.cmd, align_payload(bus.wdata, w_len_c)};
                r_len  <= w_len_c;
                r_bits <= '0;
            end else if (w_fall) begin
                r_tx   <= {r_tx[FRAME_BITS-2:0], 1'b0};
                r_bits <= r_bits + 6'd1;
            end
            if (w_rise) begin
                r_rx <= {r_rx[30:0], bus.spi_sdo};
            end
        end
    end

    // Publish the payload bits and pulse done on the first cycle with csn high.
    always_ff @(posedge clk_ref or negedge sys_rstn) begin
        if (!sys_rstn) begin
            r_done  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_done <= w_frame_end;
            if (w_frame_end) begin
                r_rdata <= r_rx & payload_mask(r_len);
            end
        end
    end

    assign bus.spi_csn = w_csn;
    assign bus.spi_sck = w_sck;
    assign bus.spi_sdi = w_sdi;
    assign bus.busy    = (r_state != IDLE);
    assign bus.done    = r_done;
    assign bus.rdata   = r_rdata;

endmodule

// File: tb/tb_spi_cmd_master.sv
module tb_spi_cmd_master;
    import spi_cmd_master_pkg::*;

    localparam int CLK_DIV  = 2;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int CS_IDLE  = 4;

    typedef struct {
        logic [31:0] rdata;
        int          nbits;
        logic [39:0] tx;
        int          low;
        int          start_cyc;
    } exp_t;

    logic clk_ref  = 1'b0;
    logic sys_rstn = 1'b0;
    int   cyc      = 0;

    spi_cmd_master_if bus();

    spi_cmd_master #(
        .CLK_DIV  (CLK_DIV),
        .CS_SETUP (CS_SETUP),
        .CS_HOLD  (CS_HOLD),
        .CS_IDLE  (CS_IDLE)
    ) u_dut (
        .clk_ref  (clk_ref),
        .sys_rstn (sys_rstn),
        .bus      (bus)
    );

    always #5 clk_ref = ~clk_ref;
    always @(posedge clk_ref) cyc <= cyc + 1;

    int   n_cmp    = 0;
    int   n_err    = 0;
    exp_t q[$];
    int   done_cnt = 0;
    logic chk_gap  = 1'b0;

    // sdo source: loopback of sdi, or a slave returning slv_pat MSB first
    logic        sdo_mode = 1'b0;
    logic [39:0] slv_pat  = {8'h00, 32'h1234_5678};
    int          slv_k    = 0;
    logic        slv_bit;

    always @(negedge bus.spi_csn or posedge bus.spi_sck) begin
        if (bus.spi_sck) slv_k = slv_k + 1;
        else             slv_k = 0;
    end

    always_comb begin
        slv_bit = 1'b0;
        if (slv_k < 40) slv_bit = slv_pat[39 - slv_k];
    end

    assign bus.spi_sdo = sdo_mode ? slv_bit : bus.spi_sdi;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: frame measurements at negedge, scoreboard pop on done
    logic        p_csn = 1'b1, p_sck = 1'b0, p_sdi = 1'b0;
    int          low_cnt = 0, rises = 0, viol = 0, rise_cyc = 0;
    logic [39:0] sdi_cap = '0;

    always @(negedge clk_ref) begin
        exp_t e;
        if (!bus.spi_csn && p_csn) begin
            low_cnt = 0;
            rises   = 0;
            sdi_cap = '0;
            if (chk_gap) check("csn_high_gap", 64'(cyc - rise_cyc), 64'(CS_IDLE + 1));
        end
        if (bus.spi_csn && !p_csn) rise_cyc = cyc;
        if (!bus.spi_csn) low_cnt++;
        if (!bus.spi_csn && bus.spi_sck && !p_sck) begin
            rises++;
            sdi_cap = {sdi_cap[38:0], bus.spi_sdi};
        end
        if (!bus.spi_csn && !p_csn && (bus.spi_sdi != p_sdi) && !(p_sck && !bus.spi_sck)) viol++;
        if (bus.spi_csn && bus.spi_sck) viol++;
        if (bus.done) begin
            done_cnt++;
            if (q.size() == 0) begin
                check("unexpected_done", 64'(1), 64'(0));
            end else begin
                e = q.pop_front();
                check("rdata", 64'(bus.rdata), 64'(e.rdata));
                check("sck_rises", 64'(rises), 64'(e.nbits));
                check("sdi_bits", 64'(sdi_cap), 64'(e.tx));
                check("csn_low_cycles", 64'(low_cnt), 64'(e.low));
                if (e.start_cyc >= 0) check("start_to_done", 64'(cyc - e.start_cyc), 64'(e.low + 1));
                check("sdi_edge_violations", 64'(viol), 64'(0));
            end
        end
        p_csn = bus.spi_csn;
        p_sck = bus.spi_sck;
        p_sdi = bus.spi_sdi;
    end

    task automatic wait_done(input int target, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk_ref);
            if (done_cnt >= target) ok = 1;
        end
        if (!ok) check("done_timeout", 64'(done_cnt), 64'(target));
    endtask

    task automatic wait_busy(input logic v, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk_ref);
            if (bus.busy === v) ok = 1;
        end
        if (!ok) check("busy_timeout", 64'(bus.busy), 64'(v));
    endtask

    task automatic push(input logic [39:0] tx, input int nb, input int low,
                        input logic [31:0] rd, input int sc);
        exp_t e;
        e.rdata = rd; e.nbits = nb; e.tx = tx; e.low = low; e.start_cyc = sc;
        q.push_back(e);
    endtask

    task automatic send(input logic [7:0] c, input logic [2:0] l, input logic [31:0] w,
                        input logic [39:0] tx, input int nb, input int low,
                        input logic [31:0] rd, input logic slave);
        int target;
        sdo_mode = slave;
        @(posedge clk_ref); #1;
        bus.start = 1'b1; bus.cmd = c; bus.len = l; bus.wdata = w;
        push(tx, nb, low, rd, cyc);
        target = done_cnt + 1;
        @(posedge clk_ref); #1;
        // changes after acceptance must not reach the frame
        bus.start = 1'b0; bus.cmd = ~c; bus.len = 3'd3; bus.wdata = ~w;
        wait_done(target, 400);
        wait_busy(1'b0, 20);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int target;
        bus.start = 1'b0; bus.cmd = 8'h00; bus.len = 3'd0; bus.wdata = 32'h0;

        // 1: reset state held during and after reset
        repeat (3) @(negedge clk_ref);
        #2 sys_rstn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_ref);
            check("idle_state", {bus.spi_csn, bus.spi_sck, bus.spi_sdi, bus.busy, bus.done, bus.rdata},
                  {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
        end

        // 2: xdac, 2 bytes, loopback
        send(CMD_XDAC, 3'd2, 32'h0000_A55A, 40'h00_0002_A55A, 24, 100, 32'h0000_A55A, 1'b0);
        // 3: xp-adc, 4 bytes, slave answers 0x12345678
        send(CMD_XP_ADC, 3'd4, 32'hDEAD_BEEF, 40'h01_DEAD_BEEF, 40, 164, 32'h1234_5678, 1'b1);
        // 4: command only, and len clamping
        send(CMD_XP_ADC, 3'd0, 32'hFFFF_FFFF, 40'h00_0000_0001, 8, 36, 32'h0, 1'b0);
        send(CMD_XDAC, 3'd7, 32'hC0FF_EE11, 40'h02_C0FF_EE11, 40, 164, 32'hC0FF_EE11, 1'b0);

        // 5: start held high -> two back-to-back frames, pulses while busy ignored
        sdo_mode = 1'b0;
        @(posedge clk_ref); #1;
        bus.start = 1'b1; bus.cmd = CMD_XP_ADC; bus.len = 3'd1; bus.wdata = 32'hAAAA_553C;
        push(40'h00_0000_013C, 16, 68, 32'h0000_003C, cyc);
        push(40'h00_0000_013C, 16, 68, 32'h0000_003C, -1);
        target = done_cnt + 1;
        wait_done(target, 200);
        chk_gap = 1'b1;
        wait_busy(1'b0, 20);
        wait_busy(1'b1, 5);
        #1;
        bus.start = 1'b0; bus.cmd = CMD_XDAC; bus.len = 3'd4; bus.wdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            repeat (5) @(posedge clk_ref);
            #1 bus.start = 1'b1;
            @(posedge clk_ref);
            #1 bus.start = 1'b0;
        end
        wait_done(target + 1, 200);
        chk_gap = 1'b0;
        wait_busy(1'b0, 20);
        repeat (10) @(negedge clk_ref);
        check("no_extra_frame_busy", 64'(bus.busy), 64'(0));

        // 6: reset at bit 10 aborts, then a clean frame
        sdo_mode = 1'b0;
        @(posedge clk_ref); #1;
        bus.start = 1'b1; bus.cmd = CMD_XP_ADC; bus.len = 3'd2; bus.wdata = 32'h0000_1234;
        push(40'h00_0001_1234, 24, 100, 32'h0000_1234, cyc);
        @(posedge clk_ref); #1;
        bus.start = 1'b0;
        begin
            bit ok = 0;
            for (int i = 0; i < 200 && !ok; i++) begin
                @(negedge clk_ref);
                if (rises >= 10) ok = 1;
            end
            if (!ok) check("bit10_timeout", 64'(rises), 64'(10));
        end
        #2 sys_rstn = 1'b0;
        void'(q.pop_back());
        #1 check("abort_pins", {bus.spi_csn, bus.spi_sck, bus.busy, bus.done}, 4'b1000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_ref);
            check("abort_held", {bus.spi_csn, bus.spi_sck, bus.busy, bus.done}, 4'b1000);
        end
        #2 sys_rstn = 1'b1;
        repeat (3) @(negedge clk_ref);
        send(CMD_XDAC, 3'd2, 32'h0000_BEEF, 40'h00_0002_BEEF, 24, 100, 32'h0000_BEEF, 1'b0);

        repeat (20) @(negedge clk_ref);
        check("queue_empty", 64'(q.size()), 64'(0));
        check("done_count", 64'(done_cnt), 64'(7));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
